// File: rtl/iob_split_tmo_pkg.sv
// Shared definitions for the timeout-guarded native-bus splitter:
// FSM encodings, error cause codes and packed request/response field offsets.
package iob_split_tmo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_DEC  = 2'b01;
  localparam logic [1:0] CAUSE_TMO  = 2'b10;

  // Request word is {valid, addr, wdata, wstrb}; response word is {rdata, ready}.
  function automatic int req_w(input int aw, input int dw);
    return 1 + aw + dw + dw / 8;
  endfunction

  function automatic int resp_w(input int dw);
    return dw + 1;
  endfunction

  function automatic int req_valid_bit(input int aw, input int dw);
    return aw + dw + dw / 8;
  endfunction

  function automatic int req_addr_lsb(input int dw);
    return dw + dw / 8;
  endfunction

endpackage

// File: rtl/iob_split_tmo_wdog.sv
// Slave wait counter: cleared on start, counts while run, flags the last allowed cycle.
module iob_split_tmo_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic expire
);

  if (TIMEOUT == 0) begin : g_off
    assign expire = 1'b0;
  end else begin : g_on
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;

    assign expire = run && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                 cnt_q <= '0;
      else if (start)           cnt_q <= '0;
      else if (run && !expire) cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/iob_split_tmo.sv
// Registered 1-to-N native-bus splitter; completes the master itself on
// a decode miss or when the selected slave exceeds its wait budget.
module iob_split_tmo
  import iob_split_tmo_pkg::*;
#(
  parameter int              N_SLAVES = 2,
  parameter int              P_SLAVES = 31,
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF,
  localparam int NB     = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1,
  localparam int REQ_W  = req_w(ADDR_W, DATA_W),
  localparam int RESP_W = resp_w(DATA_W)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REQ_W-1:0]           m_req,
  output logic [RESP_W-1:0]          m_resp,
  output logic [N_SLAVES*REQ_W-1:0]  s_req,
  input  logic [N_SLAVES*RESP_W-1:0] s_resp,
  output logic                       err,
  output logic [1:0]                 err_cause
);

  localparam int VLD  = req_valid_bit(ADDR_W, DATA_W);
  localparam int ALSB = req_addr_lsb(DATA_W);

  state_t                          state_q, state_d;
  logic [REQ_W-2:0]                req_q;
  logic [NB-1:0]                   sel_q, sel;
  logic [1:0]                      cause_q;
  logic [ADDR_W-1:0]               m_addr;
  logic                            m_vld, hit, s_rdy;
  logic                            start, run, expire;
  logic [N_SLAVES-1:0][RESP_W-1:0] resp_arr;

  assign m_vld    = m_req[VLD];
  assign m_addr   = m_req[ALSB +: ADDR_W];
  assign sel      = m_addr[P_SLAVES -: NB];
  assign hit      = ({1'b0, sel} < (NB+1)'(N_SLAVES));
  assign resp_arr = s_resp;
  assign s_rdy    = resp_arr[sel_q][0];

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    run     = 1'b0;
    unique case (state_q)
      ST_IDLE: if (m_vld) begin
        state_d = hit ? ST_BUSY : ST_ERR;
        start   = hit;
      end
      // A slave ready in the expiry cycle wins over the timeout.
      ST_BUSY: begin
        run = !s_rdy;
        if (s_rdy)       state_d = ST_IDLE;
        else if (expire) state_d = ST_ERR;
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      sel_q   <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      if (start) begin
        req_q <= m_req[REQ_W-2:0];
        sel_q <= sel;
      end
      if (state_q == ST_IDLE && m_vld && !hit) cause_q <= CAUSE_DEC;
      else if (run && expire)                 cause_q <= CAUSE_TMO;
    end
  end

  iob_split_tmo_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .run    (run),
    .expire (expire)
  );

  // Slave valid is decoded from the state register so it drops with an async reset.
  for (genvar k = 0; k < N_SLAVES; k++) begin : g_sreq
    assign s_req[k*REQ_W +: REQ_W] = {(state_q == ST_BUSY) && (sel_q == NB'(k)), req_q};
  end

  always_comb begin
    m_resp = '0;
    if (state_q == ST_BUSY)     m_resp = resp_arr[sel_q];
    else if (state_q == ST_ERR) m_resp = {ERR_DATA, 1'b1};
  end

  assign err       = (state_q == ST_ERR);
  assign err_cause = cause_q;

endmodule
